udma_mch_reg_if: RTL and testbench



---
 rtl/udma_mch_pkg.sv | 19 +
 rtl/udma_mch_ch_regs.sv | 125 ++++++++++++
 rtl/udma_mch_reg_if.sv | 134 +++++++++++++
 tb/tb_udma_mch_reg_if.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_mch_pkg.sv
// Shared register map, CFG bit layout and reset constants for the multi-channel uDMA register interface.
package udma_mch_pkg;

  localparam logic [1:0] REG_SADDR      = 2'd0;
  localparam logic [1:0] REG_SIZE       = 2'd1;
  localparam logic [1:0] REG_CFG        = 2'd2;
  localparam logic [1:0] REG_RSVD       = 2'd3;
  localparam logic [1:0] REG_IRQ_STATUS = 2'd0;
  localparam logic [1:0] REG_IRQ_MASK   = 2'd1;
  localparam logic [1:0] REG_ERR        = 2'd2;

  localparam int CFG_CONT_BIT = 0;
  localparam int CFG_DS_LSB   = 1;
  localparam int CFG_EN_BIT   = 4;
  localparam int CFG_CLR_BIT  = 5;

  localparam logic [1:0] DATASIZE_RST = 2'b10;

endpackage

// File: rtl/udma_mch_ch_regs.sv
// One uDMA channel: staging descriptor, one-deep shadow queue, launch/clear pulses and end-of-transfer detect.
module udma_mch_ch_regs
  import udma_mch_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_saddr_i,
  input  logic                      wr_size_i,
  input  logic                      wr_cfg_i,
  input  logic [31:0]               wdata_i,
  input  logic                      ch_en_i,
  output logic [L2_AWIDTH_NOAL-1:0] startaddr_o,
  output logic [TRANS_SIZE-1:0]     size_o,
  output logic [1:0]                datasize_o,
  output logic                      continuous_o,
  output logic                      en_o,
  output logic                      clr_o,
  output logic                      eot_o,
  output logic                      ovf_o,
  output logic                      shadow_valid_o,
  output logic [1:0]                datasize_stg_o,
  output logic                      cont_stg_o
);

  typedef struct packed {
    logic [L2_AWIDTH_NOAL-1:0] startaddr;
    logic [TRANS_SIZE-1:0]     size;
    logic [1:0]                datasize;
    logic                      continuous;
  } desc_t;

  localparam desc_t DESC_RST = '{startaddr: '0, size: '0, datasize: DATASIZE_RST, continuous: 1'b0};

  desc_t stg_q, stg_d, shadow_q, shadow_d, active_q, active_d;
  logic  shadow_valid_q, shadow_valid_d;
  logic  inflight_q, inflight_d;
  logic  en_q, en_d, clr_q, clr_d, en_prev_q;
  logic  busy, cfg_en, cfg_clr;

  // inflight covers the gap between our launch pulse and the engine raising ch_en_i
  assign busy    = ch_en_i | inflight_q;
  assign cfg_clr = wr_cfg_i & wdata_i[CFG_CLR_BIT];
  assign cfg_en  = wr_cfg_i & wdata_i[CFG_EN_BIT] & ~wdata_i[CFG_CLR_BIT];

  always_comb begin
    stg_d = stg_q;
    if (wr_saddr_i) stg_d.startaddr = wdata_i[L2_AWIDTH_NOAL-1:0];
    if (wr_size_i)  stg_d.size      = wdata_i[TRANS_SIZE-1:0];
    if (wr_cfg_i) begin
      stg_d.datasize   = wdata_i[CFG_DS_LSB +: 2];
      stg_d.continuous = wdata_i[CFG_CONT_BIT];
    end

    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    active_d       = active_q;
    inflight_d     = inflight_q & ~ch_en_i;
    en_d           = 1'b0;
    clr_d          = 1'b0;
    ovf_o          = 1'b0;

    if (cfg_clr) begin
      clr_d          = 1'b1;
      shadow_valid_d = 1'b0;
      inflight_d     = 1'b0;
    end else begin
      if (cfg_en) begin
        if (shadow_valid_q) begin
          ovf_o = 1'b1;
        end else if (!busy) begin
          active_d   = stg_d;
          en_d       = 1'b1;
          inflight_d = 1'b1;
        end else begin
          shadow_d       = stg_d;
          shadow_valid_d = 1'b1;
        end
      end
      // Back-to-back: queued descriptor goes out as soon as the channel is free
      if (shadow_valid_q && !busy) begin
        active_d       = shadow_q;
        en_d           = 1'b1;
        inflight_d     = 1'b1;
        shadow_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stg_q          <= DESC_RST;
      shadow_q       <= DESC_RST;
      active_q       <= DESC_RST;
      shadow_valid_q <= 1'b0;
      inflight_q     <= 1'b0;
      en_q           <= 1'b0;
      clr_q          <= 1'b0;
      en_prev_q      <= 1'b0;
    end else begin
      stg_q          <= stg_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      shadow_valid_q <= shadow_valid_d;
      inflight_q     <= inflight_d;
      en_q           <= en_d;
      clr_q          <= clr_d;
      en_prev_q      <= ch_en_i;
    end
  end

  assign eot_o          = en_prev_q & ~ch_en_i;
  assign startaddr_o    = active_q.startaddr;
  assign size_o         = active_q.size;
  assign datasize_o     = active_q.datasize;
  assign continuous_o   = active_q.continuous;
  assign en_o           = en_q;
  assign clr_o          = clr_q;
  assign shadow_valid_o = shadow_valid_q;
  assign datasize_stg_o = stg_q.datasize;
  assign cont_stg_o     = stg_q.continuous;

endmodule

// File: rtl/udma_mch_reg_if.sv
// Multi-channel uDMA register interface: cfg address decode, read mux and global IRQ/MASK/ERR registers.
module udma_mch_reg_if
  import udma_mch_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int ADDR_W         = 5
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [31:0]                    cfg_data_i,
  input  logic [ADDR_W-1:0]              cfg_addr_i,
  input  logic                           cfg_valid_i,
  input  logic                           cfg_rwn_i,
  output logic [31:0]                    cfg_data_o,
  output logic                           cfg_ready_o,
  output logic [N_CH*L2_AWIDTH_NOAL-1:0] ch_startaddr_o,
  output logic [N_CH*TRANS_SIZE-1:0]     ch_size_o,
  output logic [N_CH*2-1:0]              ch_datasize_o,
  output logic [N_CH-1:0]                ch_continuous_o,
  output logic [N_CH-1:0]                ch_en_o,
  output logic [N_CH-1:0]                ch_clr_o,
  input  logic [N_CH-1:0]                ch_en_i,
  input  logic [N_CH-1:0]                ch_pending_i,
  input  logic [N_CH*L2_AWIDTH_NOAL-1:0] ch_curr_addr_i,
  input  logic [N_CH*TRANS_SIZE-1:0]     ch_bytes_left_i,
  output logic                           irq_o
);

  localparam int CW = ADDR_W - 2;

  logic [CW-1:0]   ch_sel;
  logic [1:0]      reg_sel;
  logic            wr_req, glb_wr;
  logic [N_CH-1:0] wmask;
  logic [N_CH-1:0] eot, ovf, shadow_valid, cont_stg;
  logic [N_CH*2-1:0] ds_stg;
  logic [N_CH-1:0] status_q, status_d, mask_q, mask_d, err_q, err_d;
  logic            irq_q;

  assign ch_sel      = cfg_addr_i[ADDR_W-1:2];
  assign reg_sel     = cfg_addr_i[1:0];
  assign wr_req      = cfg_valid_i & ~cfg_rwn_i;
  assign glb_wr      = wr_req & (ch_sel == CW'(N_CH));
  assign wmask       = cfg_data_i[N_CH-1:0];
  assign cfg_ready_o = 1'b1;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic sel;
    assign sel = wr_req & (ch_sel == CW'(c));

    udma_mch_ch_regs #(
      .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
      .TRANS_SIZE     (TRANS_SIZE)
    ) u_ch (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .wr_saddr_i     (sel & (reg_sel == REG_SADDR)),
      .wr_size_i      (sel & (reg_sel == REG_SIZE)),
      .wr_cfg_i       (sel & (reg_sel == REG_CFG)),
      .wdata_i        (cfg_data_i),
      .ch_en_i        (ch_en_i[c]),
      .startaddr_o    (ch_startaddr_o[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
      .size_o         (ch_size_o[c*TRANS_SIZE +: TRANS_SIZE]),
      .datasize_o     (ch_datasize_o[c*2 +: 2]),
      .continuous_o   (ch_continuous_o[c]),
      .en_o           (ch_en_o[c]),
      .clr_o          (ch_clr_o[c]),
      .eot_o          (eot[c]),
      .ovf_o          (ovf[c]),
      .shadow_valid_o (shadow_valid[c]),
      .datasize_stg_o (ds_stg[c*2 +: 2]),
      .cont_stg_o     (cont_stg[c])
    );
  end

  // Event sets are applied after the W1C clear so a same-cycle event is never lost
  always_comb begin
    status_d = status_q;
    mask_d   = mask_q;
    err_d    = err_q;
    if (glb_wr) begin
      case (reg_sel)
        REG_IRQ_STATUS: status_d = status_q & ~wmask;
        REG_IRQ_MASK:   mask_d   = wmask;
        REG_ERR:        err_d    = err_q & ~wmask;
        default:        ;
      endcase
    end
    status_d = status_d | eot;
    err_d    = err_d | ovf;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q <= '0;
      mask_q   <= '0;
      err_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
      irq_q    <= |(status_q & mask_q);
    end
  end

  assign irq_o = irq_q;

  always_comb begin
    cfg_data_o = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel == CW'(c)) begin
        case (reg_sel)
          REG_SADDR: cfg_data_o = 32'(ch_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]);
          REG_SIZE:  cfg_data_o = 32'(ch_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE]);
          REG_CFG:   cfg_data_o = {26'h0, ch_pending_i[c], ch_en_i[c], shadow_valid[c],
                                   ds_stg[c*2 +: 2], cont_stg[c]};
          default:   cfg_data_o = '0;
        endcase
      end
    end
    if (ch_sel == CW'(N_CH)) begin
      case (reg_sel)
        REG_IRQ_STATUS: cfg_data_o = 32'(status_q);
        REG_IRQ_MASK:   cfg_data_o = 32'(mask_q);
        REG_ERR:        cfg_data_o = 32'(err_q);
        default:        cfg_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_mch_reg_if.sv
// Scoreboard bench for udma_mch_reg_if: directed scenarios followed by randomized traffic against a queue-based model.
module tb_udma_mch_reg_if;

  localparam int N_CH   = 4;
  localparam int AW     = 12;
  localparam int TS     = 16;
  localparam int ADDR_W = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [31:0]          cfg_data_i, cfg_data_o;
  logic [ADDR_W-1:0]    cfg_addr_i;
  logic                 cfg_valid_i, cfg_rwn_i, cfg_ready_o;
  logic [N_CH*AW-1:0]   ch_startaddr_o, ch_curr_addr_i;
  logic [N_CH*TS-1:0]   ch_size_o, ch_bytes_left_i;
  logic [N_CH*2-1:0]    ch_datasize_o;
  logic [N_CH-1:0]      ch_continuous_o, ch_en_o, ch_clr_o, ch_en_i, ch_pending_i;
  logic                 irq_o;

  always #5 clk = ~clk;

  udma_mch_reg_if #(.N_CH(N_CH), .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i),
    .cfg_valid_i(cfg_valid_i), .cfg_rwn_i(cfg_rwn_i), .cfg_data_o(cfg_data_o),
    .cfg_ready_o(cfg_ready_o), .ch_startaddr_o(ch_startaddr_o), .ch_size_o(ch_size_o),
    .ch_datasize_o(ch_datasize_o), .ch_continuous_o(ch_continuous_o), .ch_en_o(ch_en_o),
    .ch_clr_o(ch_clr_o), .ch_en_i(ch_en_i), .ch_pending_i(ch_pending_i),
    .ch_curr_addr_i(ch_curr_addr_i), .ch_bytes_left_i(ch_bytes_left_i), .irq_o(irq_o)
  );

  typedef struct { int unsigned saddr; int unsigned size; int unsigned ds; int unsigned cont; } mdesc_t;
  typedef struct { int cyc; int ch; mdesc_t d; } ev_t;
  typedef struct { int cyc; int ch; } pc_t;
  typedef struct { int cyc; logic [31:0] data; } rd_t;
  typedef struct { int cyc; logic v; } irq_t;

  ev_t  launch_q[$];
  pc_t  clr_q[$];
  rd_t  rd_q[$];
  irq_t irq_q[$];

  // Reference model state
  mdesc_t          m_stg[N_CH];
  mdesc_t          m_act[N_CH];
  mdesc_t          m_sh[N_CH][$];
  logic [N_CH-1:0] m_inflight, m_prev, m_status, m_mask, m_err, m_launched;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit auto_eng = 0;
  int eng_wait[N_CH];
  int eng_run[N_CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_stg[c] = '{0, 0, 2, 0};
      m_act[c] = '{0, 0, 2, 0};
      m_sh[c].delete();
    end
    m_inflight = '0; m_prev = '0; m_status = '0; m_mask = '0; m_err = '0; m_launched = '0;
  endtask

  function automatic logic [31:0] rd_model(int ch, int r);
    if (ch < N_CH) begin
      case (r)
        0: return 32'(ch_curr_addr_i[ch*AW +: AW]);
        1: return 32'(ch_bytes_left_i[ch*TS +: TS]);
        2: return {26'h0, ch_pending_i[ch], ch_en_i[ch], m_sh[ch].size() != 0,
                   2'(m_stg[ch].ds), 1'(m_stg[ch].cont)};
        default: return 32'h0;
      endcase
    end else if (ch == N_CH) begin
      case (r)
        0: return 32'(m_status);
        1: return 32'(m_mask);
        2: return 32'(m_err);
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  // Applies this cycle's inputs to the model and queues every output expected after the coming edge
  task automatic model_step();
    bit wr, rd, busy, had_sh, clr, launch;
    int ach, r;
    mdesc_t ld;
    logic [N_CH-1:0] eot, ovf, wm;
    rd  = cfg_valid_i && cfg_rwn_i;
    wr  = cfg_valid_i && !cfg_rwn_i;
    ach = int'(cfg_addr_i) / 4;
    r   = int'(cfg_addr_i) % 4;
    if (rd) rd_q.push_back('{cyc, rd_model(ach, r)});
    if (rst) begin
      model_reset();
      irq_q.push_back('{cyc + 1, 1'b0});
      return;
    end
    irq_q.push_back('{cyc + 1, |(m_status & m_mask)});
    eot = '0; ovf = '0;
    for (int c = 0; c < N_CH; c++) begin
      busy   = ch_en_i[c] || m_inflight[c];
      had_sh = m_sh[c].size() != 0;
      clr    = 0;
      launch = 0;
      ld     = m_stg[c];
      if (wr && ach == c) begin
        if (r == 0) m_stg[c].saddr = cfg_data_i & ((32'd1 << AW) - 1);
        if (r == 1) m_stg[c].size  = cfg_data_i & ((32'd1 << TS) - 1);
        if (r == 2) begin
          m_stg[c].ds   = cfg_data_i[2:1];
          m_stg[c].cont = cfg_data_i[0];
          if (cfg_data_i[5]) clr = 1;
          else if (cfg_data_i[4]) begin
            if (had_sh) ovf[c] = 1'b1;
            else if (!busy) begin launch = 1; ld = m_stg[c]; end
            else m_sh[c].push_back(m_stg[c]);
          end
        end
      end
      if (clr) begin
        m_sh[c].delete();
        m_inflight[c] = 1'b0;
        clr_q.push_back('{cyc + 1, c});
      end else begin
        if (had_sh && !busy) begin launch = 1; ld = m_sh[c].pop_front(); end
        if (launch) begin
          m_act[c] = ld;
          m_inflight[c] = 1'b1;
          launch_q.push_back('{cyc + 1, c, ld});
        end else begin
          m_inflight[c] = m_inflight[c] && !ch_en_i[c];
        end
      end
      m_launched[c] = launch;
      eot[c]  = m_prev[c] && !ch_en_i[c];
      m_prev[c] = ch_en_i[c];
    end
    wm = cfg_data_i[N_CH-1:0];
    if (wr && ach == N_CH) begin
      if (r == 0) m_status = m_status & ~wm;
      if (r == 1) m_mask   = wm;
      if (r == 2) m_err    = m_err & ~wm;
    end
    m_status = m_status | eot;
    m_err    = m_err | ovf;
  endtask

  task automatic tick();
    if (auto_eng) begin
      for (int c = 0; c < N_CH; c++) begin
        if (eng_run[c] > 0) begin
          ch_en_i[c] = 1'b1; eng_run[c]--;
        end else if (eng_wait[c] == 0) begin
          ch_en_i[c] = 1'b1; eng_run[c] = $urandom_range(0, 5); eng_wait[c] = -1;
        end else begin
          ch_en_i[c] = 1'b0;
          if (eng_wait[c] > 0) eng_wait[c]--;
        end
      end
      ch_pending_i    = N_CH'($urandom);
      ch_curr_addr_i  = (N_CH*AW)'({$urandom, $urandom});
      ch_bytes_left_i = (N_CH*TS)'({$urandom, $urandom});
    end
    model_step();
    if (auto_eng)
      for (int c = 0; c < N_CH; c++) if (m_launched[c]) eng_wait[c] = $urandom_range(0, 2);
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input bit rd, input int ch, input int r, input logic [31:0] d);
    cfg_valid_i = 1'b1;
    cfg_rwn_i   = rd;
    cfg_addr_i  = ADDR_W'(ch * 4 + r);
    cfg_data_i  = d;
    tick();
    cfg_valid_i = 1'b0;
    cfg_rwn_i   = 1'b1;
    cfg_data_i  = '0;
  endtask

  task automatic chk_active(input int c);
    checks++;
    if (ch_startaddr_o[c*AW +: AW] !== AW'(m_act[c].saddr) || ch_size_o[c*TS +: TS] !== TS'(m_act[c].size) ||
        ch_datasize_o[c*2 +: 2] !== 2'(m_act[c].ds) || ch_continuous_o[c] !== 1'(m_act[c].cont)) begin
      errors++;
      $display("FAIL active_desc ch%0d: got saddr=%h size=%h ds=%0d cont=%0b, expected saddr=%h size=%h ds=%0d cont=%0d",
               c, ch_startaddr_o[c*AW +: AW], ch_size_o[c*TS +: TS], ch_datasize_o[c*2 +: 2], ch_continuous_o[c],
               m_act[c].saddr, m_act[c].size, m_act[c].ds, m_act[c].cont);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output
  ev_t  me;
  pc_t  mp;
  rd_t  mr;
  irq_t mi;
  always @(negedge clk) begin
    if (cfg_valid_i && cfg_rwn_i) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++; $display("FAIL read addr=%0d: got %h with no expected value", cfg_addr_i, cfg_data_o);
      end else begin
        mr = rd_q.pop_front();
        if (cfg_data_o !== mr.data || mr.cyc != cyc) begin
          errors++; $display("FAIL read addr=%0d cyc %0d: got %h, expected %h", cfg_addr_i, cyc, cfg_data_o, mr.data);
        end
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      if (ch_en_o[c]) begin
        checks++;
        if (launch_q.size() == 0) begin
          errors++; $display("FAIL launch ch%0d cyc %0d: unexpected ch_en_o pulse", c, cyc);
        end else begin
          me = launch_q.pop_front();
          if (me.cyc != cyc || me.ch != c || ch_startaddr_o[c*AW +: AW] !== AW'(me.d.saddr) ||
              ch_size_o[c*TS +: TS] !== TS'(me.d.size) || ch_datasize_o[c*2 +: 2] !== 2'(me.d.ds) ||
              ch_continuous_o[c] !== 1'(me.d.cont)) begin
            errors++;
            $display("FAIL launch ch%0d cyc %0d: got saddr=%h size=%h ds=%0d cont=%0b, expected ch%0d cyc %0d saddr=%h size=%h ds=%0d cont=%0d",
                     c, cyc, ch_startaddr_o[c*AW +: AW], ch_size_o[c*TS +: TS], ch_datasize_o[c*2 +: 2],
                     ch_continuous_o[c], me.ch, me.cyc, me.d.saddr, me.d.size, me.d.ds, me.d.cont);
          end
        end
      end
      if (ch_clr_o[c]) begin
        checks++;
        if (clr_q.size() == 0) begin
          errors++; $display("FAIL clear ch%0d cyc %0d: unexpected ch_clr_o pulse", c, cyc);
        end else begin
          mp = clr_q.pop_front();
          if (mp.cyc != cyc || mp.ch != c) begin
            errors++; $display("FAIL clear ch%0d cyc %0d: expected ch%0d at cyc %0d", c, cyc, mp.ch, mp.cyc);
          end
        end
      end
    end
    while (launch_q.size() != 0 && launch_q[0].cyc <= cyc) begin
      me = launch_q.pop_front();
      checks++; errors++;
      $display("FAIL launch ch%0d: no ch_en_o pulse at cyc %0d, expected 1", me.ch, me.cyc);
    end
    while (clr_q.size() != 0 && clr_q[0].cyc <= cyc) begin
      mp = clr_q.pop_front();
      checks++; errors++;
      $display("FAIL clear ch%0d: no ch_clr_o pulse at cyc %0d, expected 1", mp.ch, mp.cyc);
    end
    if (irq_q.size() != 0 && irq_q[0].cyc == cyc) begin
      mi = irq_q.pop_front();
      checks++;
      if (irq_o !== mi.v) begin
        errors++; $display("FAIL irq cyc %0d: got %b, expected %b", cyc, irq_o, mi.v);
      end
    end
  end

  task automatic random_phase(input int n);
    int k, ch, r;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: do_op(1, $urandom_range(0, 7), $urandom_range(0, 3), 32'h0);
        3, 4:    do_op(0, $urandom_range(0, 7), $urandom_range(0, 1), $urandom);
        5, 6, 7: begin
          ch = $urandom_range(0, N_CH - 1);
          d = $urandom;
          d[5] = ($urandom_range(0, 7) == 0);
          d[4] = ($urandom_range(0, 3) != 0);
          do_op(0, ch, 2, d);
        end
        8: begin
          r = $urandom_range(0, 3);
          do_op(0, N_CH, r, $urandom);
        end
        default: tick();
      endcase
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1; cfg_addr_i = '0; cfg_data_i = '0;
    ch_en_i = '0; ch_pending_i = 4'b1010;
    ch_curr_addr_i = (N_CH*AW)'(48'h123_456_789_abc);
    ch_bytes_left_i = (N_CH*TS)'(64'h1111_2222_3333_4444);
    for (int c = 0; c < N_CH; c++) begin eng_wait[c] = -1; eng_run[c] = 0; end
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset values of every register, including out-of-range and reserved slots
    for (int ch = 0; ch < 8; ch++)
      for (int r = 0; r < 4; r++) do_op(1, ch, r, 32'h0);
    for (int c = 0; c < N_CH; c++) chk_active(c);

    // Idle channel 1: immediate launch
    do_op(0, 1, 0, 32'h100);
    do_op(0, 1, 1, 32'h40);
    do_op(0, 1, 2, 32'h11);
    tick();
    chk_active(1);
    ch_en_i[1] = 1'b1; repeat (3) tick();
    ch_en_i[1] = 1'b0; repeat (2) tick();
    do_op(1, N_CH, 0, 32'h0);

    // Channel 0 busy: descriptor B goes to shadow, then auto-launches on en_i fall
    ch_en_i[0] = 1'b1; tick();
    do_op(0, 0, 0, 32'h200);
    do_op(0, 0, 1, 32'h10);
    do_op(0, 0, 2, 32'h17);
    do_op(1, 0, 2, 32'h0);
    ch_en_i[0] = 1'b0; tick();
    tick();
    do_op(1, N_CH, 0, 32'h0);
    do_op(1, 0, 2, 32'h0);

    // Shadow full: third request is dropped and flagged
    ch_en_i[0] = 1'b1; tick();
    do_op(0, 0, 0, 32'h300);
    do_op(0, 0, 2, 32'h13);
    do_op(0, 0, 0, 32'h3ff);
    do_op(0, 0, 2, 32'h15);
    do_op(1, N_CH, 2, 32'h0);
    do_op(1, 0, 2, 32'h0);
    chk_active(0);
    do_op(0, N_CH, 2, 32'h1);
    do_op(1, N_CH, 2, 32'h0);
    ch_en_i[0] = 1'b0; repeat (2) tick();
    chk_active(0);
    ch_en_i[0] = 1'b1; tick();
    ch_en_i[0] = 1'b0; tick();

    // Mask ch2, event raises irq; W1C colliding with a new event keeps the bit set
    do_op(0, N_CH, 0, 32'hF);
    do_op(0, N_CH, 1, 32'h4);
    ch_en_i[2] = 1'b1; repeat (2) tick();
    ch_en_i[2] = 1'b0; repeat (3) tick();
    ch_en_i[2] = 1'b1; tick();
    ch_en_i[2] = 1'b0;
    do_op(0, N_CH, 0, 32'h4);
    do_op(1, N_CH, 0, 32'h0);
    repeat (2) tick();

    // Channel 3 busy with shadow full, then clear
    ch_en_i[3] = 1'b1; tick();
    do_op(0, 3, 2, 32'h10);
    do_op(0, 3, 2, 32'h30);
    do_op(1, 3, 2, 32'h0);
    ch_en_i[3] = 1'b0; repeat (3) tick();
    do_op(1, 3, 2, 32'h0);

    // Reset in the cycle a queued descriptor would auto-launch
    ch_en_i[0] = 1'b1; tick();
    do_op(0, 0, 2, 32'h10);
    ch_en_i[0] = 1'b0; rst = 1'b1; tick();
    tick();
    rst = 1'b0; repeat (2) tick();
    do_op(1, 0, 2, 32'h0);
    do_op(1, N_CH, 0, 32'h0);
    for (int c = 0; c < N_CH; c++) chk_active(c);

    auto_eng = 1;
    random_phase(800);
    auto_eng = 0;
    ch_en_i = '0;
    repeat (4) tick();
    for (int c = 0; c < N_CH; c++) chk_active(c);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
